// File: rtl/aes_sched_pkg.sv
// ============================================================================
// Module      : aes_sched_pkg
// Description : Shared types and constants for the AES decrypt scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] KL_INVALID = 2'b00;
    localparam logic [1:0] KL_128     = 2'b01;
    localparam logic [1:0] KL_192     = 2'b10;
    localparam logic [1:0] KL_256     = 2'b11;

    // Cycles from core start to first core_ready for each key length
    localparam int LAT_128 = 12;
    localparam int LAT_192 = 14;
    localparam int LAT_256 = 16;

    function automatic int core_latency(input logic [1:0] kl);
        case (kl)
            KL_192:  return LAT_192;
            KL_256:  return LAT_256;
            default: return LAT_128;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_decrypt_scheduler_if.sv
// ============================================================================
// Module      : aes_decrypt_scheduler_if
// Description : Request, core and response signals of the decrypt scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_decrypt_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [256*NUM_REQ-1:0] req_key;
    logic [2*NUM_REQ-1:0]   req_key_len;
    logic [128*NUM_REQ-1:0] req_ct;

    logic                   core_start;
    logic                   core_reset;
    logic [255:0]           core_key;
    logic [1:0]             core_key_len;
    logic [127:0]           core_ct;
    logic                   core_ready;
    logic [127:0]           core_pt;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IW-1:0]          rsp_id;
    logic [127:0]           rsp_pt;
    logic                   rsp_error;

    modport slave (
        input  req_valid, req_key, req_key_len, req_ct,
        input  core_ready, core_pt, rsp_ready,
        output req_ready, core_start, core_reset, core_key, core_key_len, core_ct,
        output rsp_valid, rsp_id, rsp_pt, rsp_error
    );

    modport master (
        output req_valid, req_key, req_key_len, req_ct,
        output core_ready, core_pt, rsp_ready,
        input  req_ready, core_start, core_reset, core_key, core_key_len, core_ct,
        input  rsp_valid, rsp_id, rsp_pt, rsp_error
    );

endinterface

`default_nettype wire

// File: rtl/aes_decrypt_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; search begins at the pointer position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IW-1:0]      i_ptr,
    input  wire logic               i_en,
    output logic      [NUM_REQ-1:0] o_gnt,
    output logic      [IW-1:0]      o_idx,
    output logic                    o_valid
);

    int          w_pos;
    logic [IW-1:0] w_sel;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_pos = int'(i_ptr) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_sel = IW'(w_pos);
            if (i_en && !o_valid && i_req[w_sel]) begin
                o_gnt[w_sel] = 1'b1;
                o_idx        = w_sel;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_decrypt_scheduler.sv
// ============================================================================
// Module      : aes_decrypt_scheduler
// Description : Shares one AES decrypt core among NUM_REQ requesters with a
//               watchdog on core completion and a tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_decrypt_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 31
) (
    input wire logic clk,
    input wire logic reset,
    aes_decrypt_scheduler_if.slave bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t         r_state;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  r_id;
    logic [255:0]   r_key;
    logic [1:0]     r_kl;
    logic [127:0]   r_ct;
    logic [127:0]   r_rsp_pt;
    logic           r_core_start;
    logic           r_abort;
    logic           r_rsp_valid;
    logic           r_rsp_error;
    logic [WW-1:0]  r_wdog;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_gnt_any;
    logic [IW-1:0]      w_ptr_nxt;
    logic [255:0]       w_sel_key;
    logic [1:0]         w_sel_kl;
    logic [127:0]       w_sel_ct;

    // Grants are only ever offered while idle, so RESP never overlaps an accept
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .i_en    (r_state == ST_IDLE),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_any)
    );

    assign w_ptr_nxt = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IW'(1);
    assign w_sel_key = bus.req_key[int'(w_gnt_idx)*256 +: 256];
    assign w_sel_kl  = bus.req_key_len[int'(w_gnt_idx)*2 +: 2];
    assign w_sel_ct  = bus.req_ct[int'(w_gnt_idx)*128 +: 128];

    assign bus.req_ready    = w_gnt;
    assign bus.core_start   = r_core_start;
    assign bus.core_reset   = reset | r_abort;
    assign bus.core_key     = r_key;
    assign bus.core_key_len = r_kl;
    assign bus.core_ct      = r_ct;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_id;
    assign bus.rsp_pt       = r_rsp_pt;
    assign bus.rsp_error    = r_rsp_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_key        <= '0;
            r_kl         <= KL_INVALID;
            r_ct         <= '0;
            r_rsp_pt     <= '0;
            r_core_start <= 1'b0;
            r_abort      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_core_start <= 1'b0;
            r_abort      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_any) begin
                        r_id  <= w_gnt_idx;
                        r_key <= w_sel_key;
                        r_kl  <= w_sel_kl;
                        r_ct  <= w_sel_ct;
                        r_ptr <= w_ptr_nxt;
                        if (w_sel_kl == KL_INVALID) begin
                            r_rsp_pt    <= '0;
                            r_rsp_error <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_core_start <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes precedence over an expiring watchdog
                    if (bus.core_ready) begin
                        r_rsp_pt    <= bus.core_pt;
                        r_rsp_error <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_wdog == WW'(TIMEOUT - 1)) begin
                        r_abort <= 1'b1;
                        r_state <= ST_ABORT;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                ST_ABORT: begin
                    r_rsp_pt    <= '0;
                    r_rsp_error <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_decrypt_scheduler.sv
// ============================================================================
// Module      : tb_aes_decrypt_scheduler
// Description : Randomized scoreboard bench with a behavioural core model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_decrypt_scheduler;
    import aes_sched_pkg::*;

    localparam int N  = 4;
    localparam int TO = 31;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    aes_decrypt_scheduler_if #(.NUM_REQ(N)) bus ();

    aes_decrypt_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [127:0] pt;
        logic         err;
        int           rise;
    } exp_t;

    exp_t         q_exp[$];
    int           g_log[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;

    logic [N-1:0] pend;
    logic [255:0] jkey [N];
    logic [1:0]   jkl  [N];
    logic [127:0] jct  [N];
    int           drop_at [N];
    bit           reload;

    bit           m_busy;
    int           m_ptr;
    int           exp_start, exp_abort;
    logic [255:0] cur_key;
    logic [1:0]   cur_kl;
    logic [127:0] cur_ct;

    bit           core_busy, core_hang, core_kill, core_new;
    int           core_done;
    logic [255:0] ckey;
    logic [1:0]   ckl;
    logic [127:0] cct;

    int           rsp_mode;
    int           stall_cnt;

    logic         mon_pv, mon_perr, mon_phs;
    logic [127:0] mon_ppt;
    logic [1:0]   mon_pid;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the decrypt function; the FIPS-197 vector maps to its known plaintext
    function automatic logic [127:0] core_fn(logic [255:0] k, logic [1:0] kl, logic [127:0] ct);
        if (k == {FIPS_KEY, 128'h0} && kl == KL_128 && ct == FIPS_CT) return FIPS_PT;
        return ct ^ k[255:128] ^ {k[63:0], k[127:64]} ^ {64{kl}};
    endfunction

    function automatic int winner(logic [N-1:0] v, int p);
        for (int off = 0; off < N; off++)
            if (v[(p + off) % N]) return (p + off) % N;
        return -1;
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_job(int i, logic [255:0] k, logic [1:0] kl, logic [127:0] ct);
        jkey[i] = k;
        jkl[i]  = kl;
        jct[i]  = ct;
        pend[i] = 1'b1;
    endtask

    task automatic load_rand(int i, bit allow_invalid);
        logic [255:0] k;
        logic [127:0] ct;
        logic [1:0]   kl;
        k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ct = {$urandom, $urandom, $urandom, $urandom};
        kl = (allow_invalid && $urandom_range(0, 7) == 0) ? KL_INVALID : 2'($urandom_range(1, 3));
        load_job(i, k, kl, ct);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (drop_at[i] == cyc) begin
                drop_at[i] = -1;
                if (reload) load_rand(i, 0);
                else        pend[i] = 1'b0;
            end
        end
        if (core_kill) begin
            core_kill      = 1'b0;
            core_busy      = 1'b0;
            bus.core_ready = 1'b0;
        end
        if (core_new) begin
            core_new       = 1'b0;
            bus.core_ready = 1'b0;
            bus.core_pt    = {$urandom, $urandom, $urandom, $urandom};
        end
        if (core_busy && !core_hang && cyc == core_done) begin
            bus.core_ready = 1'b1;
            bus.core_pt    = core_fn(ckey, ckl, cct);
            core_busy      = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]             = pend[i];
            bus.req_key[i*256 +: 256]    = jkey[i];
            bus.req_key_len[i*2 +: 2]    = jkl[i];
            bus.req_ct[i*128 +: 128]     = jct[i];
        end
        case (rsp_mode)
            1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
            2:       bus.rsp_ready = (stall_cnt >= 5);
            default: bus.rsp_ready = 1'b1;
        endcase
    endtask

    task automatic observe();
        logic [N-1:0] one;
        logic [N-1:0] expg;
        int           w;
        exp_t         e;
        one  = 1;
        w    = (!m_busy && pend != 0) ? winner(pend, m_ptr) : -1;
        expg = (w >= 0) ? (one << w) : '0;
        chk("req_ready", bus.req_ready, expg);
        if (w >= 0) begin
            g_log.push_back(w);
            m_busy     = 1'b1;
            m_ptr      = (w + 1) % N;
            drop_at[w] = cyc + 1;
            cur_key    = jkey[w];
            cur_kl     = jkl[w];
            cur_ct     = jct[w];
            e.id       = w;
            if (jkl[w] == KL_INVALID) begin
                e.err = 1'b1; e.pt = '0; e.rise = cyc + 1;
                exp_start = -1; exp_abort = -1;
            end else if (core_hang) begin
                e.err = 1'b1; e.pt = '0; e.rise = cyc + 3 + TO;
                exp_start = cyc + 1; exp_abort = cyc + 2 + TO;
            end else begin
                e.err = 1'b0; e.pt = core_fn(jkey[w], jkl[w], jct[w]);
                e.rise = cyc + 2 + core_latency(jkl[w]);
                exp_start = cyc + 1; exp_abort = -1;
            end
            q_exp.push_back(e);
        end
        if (bus.core_start) begin
            chk("core_start_cycle", 256'(cyc), 256'(exp_start));
            exp_start = -1;
            chk("core_key", bus.core_key, cur_key);
            chk("core_key_len", 256'(bus.core_key_len), 256'(cur_kl));
            chk("core_ct", 256'(bus.core_ct), 256'(cur_ct));
            ckey      = bus.core_key;
            ckl       = bus.core_key_len;
            cct       = bus.core_ct;
            core_busy = 1'b1;
            core_new  = 1'b1;
            core_done = cyc + core_latency(ckl);
        end
        if (bus.core_reset) begin
            chk("abort_cycle", 256'(cyc), 256'(exp_abort));
            exp_abort = -1;
            core_kill = 1'b1;
        end
        if (bus.rsp_valid && !bus.rsp_ready) stall_cnt++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            m_busy    = 1'b0;
            stall_cnt = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #4;
        observe();
    endtask

    task automatic wait_idle(int budget);
        bit dropping;
        for (int k = 0; k < budget; k++) begin
            step();
            dropping = 1'b0;
            for (int i = 0; i < N; i++) if (drop_at[i] >= 0) dropping = 1'b1;
            if (!m_busy && pend == 0 && q_exp.size() == 0 && !dropping) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle timeout got busy=%0d queued=%0d required idle (cycle %0d)",
                 m_busy, q_exp.size(), cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pend  = '0;
        for (int i = 0; i < N; i++) drop_at[i] = -1;
        q_exp.delete();
        m_busy = 1'b0; m_ptr = 0; exp_start = -1; exp_abort = -1;
        core_kill = 1'b1; stall_cnt = 0;
        drive();
        @(negedge clk);
        drive();
        #4;
        chk("rst_req_ready", 256'(bus.req_ready), 256'(0));
        chk("rst_core_start", 256'(bus.core_start), 256'(0));
        chk("rst_core_reset", 256'(bus.core_reset), 256'(1));
        chk("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        chk("rst_rsp_error", 256'(bus.rsp_error), 256'(0));
        chk("rst_rsp_pt", 256'(bus.rsp_pt), 256'(0));
        chk("rst_rsp_id", 256'(bus.rsp_id), 256'(0));
        chk("rst_core_key", bus.core_key, 256'(0));
        chk("rst_core_key_len", 256'(bus.core_key_len), 256'(0));
        chk("rst_core_ct", 256'(bus.core_ct), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        drive();
        #4;
        observe();
    endtask

    // Response monitor: timing, stability and content against the scoreboard
    initial begin : monitor
        exp_t e;
        mon_pv = 1'b0; mon_phs = 1'b0; mon_perr = 1'b0; mon_ppt = '0; mon_pid = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                mon_pv = 1'b0;
                continue;
            end
            if (bus.rsp_valid && !mon_pv) begin
                if (q_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected got id=%0d pt=%0h required no response (cycle %0d)",
                             bus.rsp_id, bus.rsp_pt, cyc);
                end else begin
                    chk("rsp_rise_cycle", 256'(cyc), 256'(q_exp[0].rise));
                end
            end
            if (bus.rsp_valid && mon_pv && !mon_phs) begin
                chk("rsp_stable_pt", 256'(bus.rsp_pt), 256'(mon_ppt));
                chk("rsp_stable_id", 256'(bus.rsp_id), 256'(mon_pid));
                chk("rsp_stable_err", 256'(bus.rsp_error), 256'(mon_perr));
            end
            if (bus.rsp_valid && bus.rsp_ready && q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk("rsp_id", 256'(bus.rsp_id), 256'(e.id));
                chk("rsp_pt", 256'(bus.rsp_pt), 256'(e.pt));
                chk("rsp_error", 256'(bus.rsp_error), 256'(e.err));
            end
            mon_pv   = bus.rsp_valid;
            mon_ppt  = bus.rsp_pt;
            mon_pid  = bus.rsp_id;
            mon_perr = bus.rsp_error;
            mon_phs  = bus.rsp_valid && bus.rsp_ready;
        end
    end

    initial begin : stimulus
        bus.req_valid = '0; bus.req_key = '0; bus.req_key_len = '0; bus.req_ct = '0;
        bus.core_ready = 1'b0; bus.core_pt = '0; bus.rsp_ready = 1'b1;
        pend = '0; reload = 1'b0; core_hang = 1'b0; core_busy = 1'b0;
        core_new = 1'b0; core_kill = 1'b0; rsp_mode = 0; stall_cnt = 0;
        m_busy = 1'b0; m_ptr = 0; exp_start = -1; exp_abort = -1;
        for (int i = 0; i < N; i++) begin
            drop_at[i] = -1; jkey[i] = '0; jkl[i] = '0; jct[i] = '0;
        end

        do_reset();

        load_job(0, {FIPS_KEY, 128'h0}, KL_128, FIPS_CT);
        wait_idle(200);

        load_job(2, {8{$urandom}}, KL_INVALID, {4{$urandom}});
        wait_idle(50);

        core_hang = 1'b1;
        load_rand(1, 0);
        wait_idle(100);
        core_hang = 1'b0;
        load_rand(3, 0);
        wait_idle(100);

        rsp_mode = 2;
        load_rand(1, 0);
        load_rand(3, 0);
        wait_idle(200);
        rsp_mode = 0;

        load_rand(3, 0);
        for (int k = 0; k < 6; k++) step();
        do_reset();
        for (int k = 0; k < 30; k++) step();

        g_log.delete();
        reload = 1'b1;
        for (int i = 0; i < N; i++) load_rand(i, 0);
        for (int k = 0; k < 300 && g_log.size() < 5; k++) step();
        reload = 1'b0;
        wait_idle(300);
        if (g_log.size() < 5) begin
            checks++;
            errors++;
            $display("FAIL rr_grants got %0d grants required 5", g_log.size());
        end else begin
            chk("rr_order0", 256'(g_log[0]), 256'(0));
            chk("rr_order1", 256'(g_log[1]), 256'(1));
            chk("rr_order2", 256'(g_log[2]), 256'(2));
            chk("rr_order3", 256'(g_log[3]), 256'(3));
            chk("rr_order4", 256'(g_log[4]), 256'(0));
        end

        rsp_mode = 1;
        for (int k = 0; k < 2000; k++) begin
            step();
            for (int i = 0; i < N; i++)
                if (!pend[i] && drop_at[i] < 0 && $urandom_range(0, 15) == 0) load_rand(i, 1);
        end
        wait_idle(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_decrypt_scheduler.md
# aes_decrypt_scheduler

Sequencer and round-robin arbiter that shares one AES decryption core among `NUM_REQ` requesters. It accepts one job at a time: key, key length and ciphertext. It issues a single-cycle start to the core, then watches for core completion under a watchdog. The plaintext is returned on a valid/ready response channel tagged with the requester index. It sits between the bus-side request ports and the decrypt core, and owns the core's reset.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 31: WAIT cycles allowed before the job is aborted. Must be greater than 17.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, `NUM_REQ`: per-requester job valid. The requester holds it until it sees its `req_ready`.
- `req_ready`, out, `NUM_REQ`: one-hot, single-cycle accept.
- `req_key`, in, 256·`NUM_REQ`: key of requester i at `[256i+255:256i]`.
- `req_key_len`, in, 2·`NUM_REQ`: 01 = AES-128, 10 = AES-192, 11 = AES-256, 00 = invalid.
- `req_ct`, in, 128·`NUM_REQ`: ciphertext.
- `core_start`, out, 1: start pulse to the core.
- `core_reset`, out, 1: core reset. Equals `reset` OR the abort pulse.
- `core_key`, out, 256: latched key.
- `core_key_len`, out, 2: latched key length.
- `core_ct`, out, 128: latched ciphertext.
- `core_ready`, in, 1: core done level.
- `core_pt`, in, 128: core plaintext.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response accept.
- `rsp_id`, out, clog2(`NUM_REQ`): index of the requester that owns the response.
- `rsp_pt`, out, 128: plaintext. Zero when `rsp_error` is 1.
- `rsp_error`, out, 1: job failed, either invalid key length or timeout.

## Operation
- States:
  - IDLE: if any `req_valid` is high, grant the round-robin winner, pulse its `req_ready` and latch `id`, `key`, `key_len` and `ct`. If `key_len`==00, go to RESP with error; otherwise go to ISSUE.
  - ISSUE: `core_start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: the watchdog counter counts from 0.
    - `core_ready`=1: capture `core_pt` and go to RESP.
    - Counter reaches `TIMEOUT` with no `core_ready`: go to ABORT.
  - ABORT: `core_reset`=1 for one cycle, set error, go to RESP.
  - RESP: hold `rsp_valid` until `rsp_ready`, then go to IDLE.
- Round robin:
  - Search starts at (last grant + 1) mod `NUM_REQ`.
  - The pointer updates only on a grant.
  - After reset the pointer makes requester 0 highest priority.
- `core_key`, `core_key_len` and `core_ct` are stable from ISSUE through WAIT/ABORT. They change only on a grant.
- `core_ready` is ignored outside WAIT. This covers the stale high level left over from the previous job.
- If `core_ready` and the timeout occur in the same cycle, `core_ready` wins.
- One job is in flight at a time. There is no grant during RESP, even when the RESP handshake completes that same cycle.
- On `reset` mid-job the job is dropped:
  - No response is issued.
  - All state is cleared and the core is held in reset.

## Timing
- Reset values:
  - `req_ready`, `core_start`, `rsp_valid` and `rsp_error` = 0.
  - `rsp_pt`, `rsp_id`, `core_key`, `core_key_len` and `core_ct` = 0.
  - State = IDLE. Pointer = 0.
  - `core_reset` = 1 while `reset` is high.
- Per-job timeline, with A = accept cycle:
  - Accept in A, `core_start` in A+1.
  - `core_ready` first high in A+13 for AES-128, A+15 for AES-192, A+17 for AES-256.
  - `rsp_valid` rises in A+14, A+16 or A+18 respectively.
- Invalid key length: `rsp_valid` rises in A+1.
- Timeout: `core_reset` pulse in cycle A+2+`TIMEOUT`; `rsp_valid` rises one cycle later.
- Back-to-back throughput: next accept no earlier than the cycle after the RESP handshake.

## Structure
- Package `aes_sched_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, ABORT, RESP);
  - key-length constants `KL_INVALID`, `KL_128`, `KL_192`, `KL_256`;
  - the expected-latency constants 12, 14 and 16.
- One sub-module, `rr_arbiter`, parameterized on `NUM_REQ`. It takes the request vector, pointer and grant-enable, and returns a one-hot grant plus the encoded index.

## Test plan
- FIPS-197 AES-128 on requester 0:
  - Stimulus: key[255:128]=000102030405060708090a0b0c0d0e0f, key_len=01, ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: `rsp_pt`=00112233445566778899aabbccddeeff, `rsp_id`=0, `rsp_valid` at A+14, `rsp_error`=0.
- Requesters 0–3 all valid continuously with `rsp_ready`=1: grants arrive in order 0,1,2,3,0, each grant after the previous RESP.
- Requester 2 with key_len=00: error response (`rsp_pt`=0) at A+1, and `core_start` never asserts.
- Core model that never raises `core_ready`: one-cycle `core_reset` at A+33 (with `TIMEOUT`=31), then `rsp_error`=1 at A+34, then the next request is processed normally.
- Hold `rsp_ready`=0 for 5 cycles in RESP: `rsp_valid`, `rsp_pt` and `rsp_id` stay stable, and no `req_ready` pulses.
- Assert `reset` during WAIT: all outputs return to reset values the following cycle, no response is issued, and the pointer returns to 0.
